// File: rtl/matrix_pkg.sv
// Shared constants and FSM encoding for the matrix ASCII transmit path.
package matrix_pkg;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;

  localparam int MAX_DIM_DEF = 5;
  localparam int BUF_LEN     = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GET  = 3'd1,
    ST_EMIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/bin2dec_ascii.sv
// Combinational byte -> sign flag plus up to three ASCII decimal digits.
module bin2dec_ascii
  import matrix_pkg::*;
(
  input  logic       i_signed,
  input  logic [7:0] i_value,
  output logic       o_neg,
  output logic [7:0] o_hund,
  output logic [7:0] o_tens,
  output logic [7:0] o_ones,
  output logic [1:0] o_ndig
);

  logic [8:0] w_mag;
  logic [6:0] w_rem;
  logic [1:0] w_h;
  logic [3:0] w_t;
  logic [3:0] w_o;

  always_comb begin
    o_neg = i_signed & i_value[7];
    // Nine bits so that -128 yields a magnitude of 128.
    w_mag = o_neg ? (9'd256 - {1'b0, i_value}) : {1'b0, i_value};
    if (w_mag >= 9'd200) begin
      w_h   = 2'd2;
      w_rem = 7'(w_mag - 9'd200);
    end else if (w_mag >= 9'd100) begin
      w_h   = 2'd1;
      w_rem = 7'(w_mag - 9'd100);
    end else begin
      w_h   = 2'd0;
      w_rem = w_mag[6:0];
    end
    w_t = 4'd0;
    for (int t = 1; t <= 9; t++) begin
      if (w_rem >= 7'(10 * t)) w_t = 4'(t);
    end
    w_o    = 4'(w_rem - 7'(10 * w_t));
    o_hund = CHAR_ZERO + {6'd0, w_h};
    o_tens = CHAR_ZERO + {4'd0, w_t};
    o_ones = CHAR_ZERO + {4'd0, w_o};
    o_ndig = (w_h != 2'd0) ? 2'd3 : ((w_t != 4'd0) ? 2'd2 : 2'd1);
  end

endmodule

// File: rtl/matrix_ascii_encoder.sv
// Streams an m x n byte matrix out to uart_tx as decimal ASCII text,
// elements separated by SEP_CHAR and each row terminated with CR LF.
module matrix_ascii_encoder
  import matrix_pkg::*;
#(
  parameter int         MAX_DIM   = MAX_DIM_DEF,
  parameter bit         SIGNED_EN = 1'b0,
  parameter logic [7:0] SEP_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] dim_m,
  input  logic [2:0] dim_n,
  input  logic [7:0] elem_data,
  input  logic       elem_valid,
  output logic       elem_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

  state_t     r_state, w_next;
  logic [2:0] r_dim_m, r_dim_n, r_row, r_col, r_idx, r_len;
  logic [7:0] r_buf [BUF_LEN];
  logic       r_error;

  logic       w_neg;
  logic [7:0] w_hund, w_tens, w_ones;
  logic [1:0] w_ndig;
  logic [7:0] w_buf [BUF_LEN];
  logic [2:0] w_pos, w_len, w_idx_next;
  logic       w_dims_ok, w_last_col, w_last_elem, w_more_bytes;

  bin2dec_ascii u_b2d (
    .i_signed (SIGNED_EN),
    .i_value  (elem_data),
    .o_neg    (w_neg),
    .o_hund   (w_hund),
    .o_tens   (w_tens),
    .o_ones   (w_ones),
    .o_ndig   (w_ndig)
  );

  assign w_dims_ok    = (dim_m != 3'd0) && (dim_m <= DIM_MAX) &&
                        (dim_n != 3'd0) && (dim_n <= DIM_MAX);
  assign w_last_col   = (r_col == r_dim_n - 3'd1);
  assign w_last_elem  = w_last_col && (r_row == r_dim_m - 3'd1);
  assign w_idx_next   = r_idx + 3'd1;
  assign w_more_bytes = (w_idx_next < r_len);
  assign error        = r_error;

  // Pack sign, significant digits and the trailing separator contiguously.
  always_comb begin
    for (int i = 0; i < BUF_LEN; i++) w_buf[i] = 8'h00;
    w_pos = 3'd0;
    if (w_neg) begin
      w_buf[w_pos] = CHAR_MINUS;
      w_pos        = w_pos + 3'd1;
    end
    if (w_ndig == 2'd3) begin
      w_buf[w_pos] = w_hund;
      w_pos        = w_pos + 3'd1;
    end
    if (w_ndig >= 2'd2) begin
      w_buf[w_pos] = w_tens;
      w_pos        = w_pos + 3'd1;
    end
    w_buf[w_pos] = w_ones;
    w_pos        = w_pos + 3'd1;
    if (w_last_col) begin
      w_buf[w_pos]         = CHAR_CR;
      w_buf[w_pos + 3'd1]  = CHAR_LF;
      w_pos                = w_pos + 3'd2;
    end else begin
      w_buf[w_pos] = SEP_CHAR;
      w_pos        = w_pos + 3'd1;
    end
    w_len = w_pos;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start && w_dims_ok) w_next = ST_GET;
      ST_GET:  if (elem_valid) w_next = ST_EMIT;
      ST_EMIT: if (!tx_busy) w_next = ST_HOLD;
      ST_HOLD: w_next = ST_WAIT;
      ST_WAIT: if (!tx_busy)
                 w_next = w_more_bytes ? ST_EMIT : (w_last_elem ? ST_DONE : ST_GET);
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    elem_ready = 1'b0;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      ST_GET: begin
        elem_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_EMIT: begin
        busy = 1'b1;
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = r_buf[r_idx];
        end
      end
      ST_HOLD, ST_WAIT: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dim_m <= 3'd0;
      r_dim_n <= 3'd0;
      r_row   <= 3'd0;
      r_col   <= 3'd0;
      r_idx   <= 3'd0;
      r_len   <= 3'd0;
      r_error <= 1'b0;
      for (int i = 0; i < BUF_LEN; i++) r_buf[i] <= 8'h00;
    end else begin
      r_error <= (r_state == ST_IDLE) && start && !w_dims_ok;
      case (r_state)
        ST_IDLE: if (start && w_dims_ok) begin
          r_dim_m <= dim_m;
          r_dim_n <= dim_n;
          r_row   <= 3'd0;
          r_col   <= 3'd0;
        end
        ST_GET: if (elem_valid) begin
          r_buf <= w_buf;
          r_len <= w_len;
          r_idx <= 3'd0;
        end
        ST_WAIT: if (!tx_busy) begin
          r_idx <= w_idx_next;
          if (!w_more_bytes) begin
            if (w_last_col) begin
              r_col <= 3'd0;
              r_row <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_ascii_encoder.md
Name: matrix_ascii_encoder

Overview:
- Encodes one m x n matrix into UART-ready ASCII. Elements arrive as binary bytes over a valid/ready stream. Output is decimal text: elements in a row are separated by SEP_CHAR, and each row ends with CR LF.
- This block is the transmit-side counterpart of uart_cmd_parser, which decodes ASCII to elements. It sits between the matrix_storage/mat_ops result stream and uart_tx, driving tx_start/tx_data and honouring tx_busy.

Parameters:
- MAX_DIM, 5, largest legal value of dim_m and dim_n.
- SIGNED_EN, 0, 1 = elements are two's complement and negatives get a leading '-'; 0 = unsigned 0..255.
- SEP_CHAR, 8'h20, byte emitted between elements of one row.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; latches dim_m/dim_n and begins a frame
- dim_m  input  3  row count, legal 1..MAX_DIM
- dim_n  input  3  column count, legal 1..MAX_DIM
- elem_data  input  8  element value, row-major order
- elem_valid  input  1  elem_data is valid
- elem_ready  output  1  encoder accepts elem_data this cycle
- tx_data  output  8  ASCII byte to uart_tx
- tx_start  output  1  one-cycle pulse; uart_tx loads tx_data
- tx_busy  input  1  uart_tx is serialising
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse when the frame's final LF has completed
- error  output  1  one-cycle pulse on an illegal start

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, and all counters and the char buffer are cleared. Reset asserted mid-frame abandons the frame immediately; no done or error is produced.
- States:
  - IDLE: on start, if dim_m or dim_n is 0 or greater than MAX_DIM, pulse error for one cycle and stay in IDLE. Otherwise latch both dims, clear the row/col counters, set busy=1, go to GET.
  - GET: elem_ready=1. When elem_valid&&elem_ready, load the char buffer and go to EMIT. elem_ready is 0 in every other state.
  - EMIT: if tx_busy==0, drive tx_data=buf[idx] and tx_start=1 for exactly one cycle, then go to HOLD.
  - HOLD: ignore tx_busy for one cycle, because uart_tx asserts busy the cycle after tx_start. Then go to WAIT.
  - WAIT: once tx_busy==0, increment idx. If idx<len, go to EMIT. Otherwise advance col/row: if more elements remain, go to GET; if the last element is done, go to DONE.
  - DONE: pulse done for one cycle, busy=0, go to IDLE.
- Char buffer: 6 entries, with len in 2..6 bytes. Entries in order:
  - '-' only if SIGNED_EN and elem_data[7]=1; magnitude = -elem_data, 9-bit wide so that -128 gives 128.
  - Decimal digits of the magnitude, most significant first, no leading zeros; value 0 gives "0". Hundreds digit is from compares against 200/100, tens from 90..10 after subtracting hundreds; combinational, no divider.
  - Separator: SEP_CHAR if col<dim_n-1, else 8'h0D then 8'h0A.
- tx_start is never asserted while tx_busy=1, and never on two consecutive cycles.
- start received while busy=1 is ignored: no error, frame unaffected.
- elem_valid gaps are allowed, and GET waits indefinitely. tx_busy stretching is allowed, and WAIT waits indefinitely.
- Total bytes in a frame = sum over elements of the digit count, plus sign count, plus (n-1)*m separators, plus 2*m for CR LF.
- dims are read only at start; later changes to dim_m/dim_n have no effect on the running frame.

Decomposition:
- Shared package matrix_pkg holds:
  - ASCII constants: CHAR_CR 8'h0D, CHAR_LF 8'h0A, CHAR_MINUS 8'h2D, CHAR_ZERO 8'h30.
  - MAX_DIM default.
  - FSM state encoding typedef.
- One sub-module, bin2dec_ascii: purely combinational. Input 8-bit value and signed flag; outputs sign flag, three ASCII digits, and digit count.

Test Plan:
- 2x2, unsigned, elements 1,23,200,0, tx_busy model busy for 10 cycles per byte -> bytes "1 23\r\n200 0\r\n" (13 bytes), then done pulses once and busy drops.
- SIGNED_EN=1, 1x3, elements 8'h80, 8'hFF, 8'h05 -> "-128 -1 5\r\n"; magnitude of -128 is correct.
- start with dim_m=0, and separately with dim_n=6 -> error one-cycle pulse, no tx_start, busy stays 0.
- Random elem_valid gaps plus tx_busy held high for 200 cycles mid-frame -> byte stream identical to the no-stall run; no tx_start while tx_busy=1.
- Second start mid-frame -> ignored, output unchanged. rst_n low mid-byte -> all outputs 0 next edge; a fresh start afterwards encodes correctly.
- 5x5 of 255 -> each row "255 255 255 255 255\r\n"; exactly 25 elem handshakes.
